// File: rtl/rr_stream_mux.sv
// ============================================================================
// rr_stream_mux : N:1 stream mux with round-robin / fixed-priority arbitration,
//                 packet lock until last beat, and a registered output stage.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module rr_stream_mux #(
  parameter  int NUM_CH = 8,
  parameter  int DATA_W = 8,
  parameter  int MODE   = 0,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  localparam int c_cw = SEL_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_rr_ptr;
  logic [SEL_W-1:0]   w_rr_nxt;
  logic [SEL_W-1:0]   r_lock_ch;
  logic [SEL_W-1:0]   w_lock_nxt;

  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_valid;
  logic               r_out_last;
  logic [SEL_W-1:0]   r_out_ch;

  logic [SEL_W-1:0]   w_search_grant;
  logic               w_search_valid;
  logic [SEL_W-1:0]   w_grant;
  logic               w_grant_valid;
  logic               w_load;
  logic               w_xfer;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_last;

  // Idle-state search; the two policies share nothing but the result wires.
  generate
    if (MODE == 0) begin : g_rr
      logic [c_cw-1:0] w_cand;
      always_comb begin
        w_search_grant = '0;
        w_search_valid = 1'b0;
        w_cand         = '0;
        for (int k = 0; k < NUM_CH; k++) begin
          w_cand = {1'b0, r_rr_ptr} + c_cw'(k);
          if (w_cand >= c_cw'(NUM_CH)) w_cand = w_cand - c_cw'(NUM_CH);
          if (!w_search_valid && in_valid[w_cand[SEL_W-1:0]]) begin
            w_search_valid = 1'b1;
            w_search_grant = w_cand[SEL_W-1:0];
          end
        end
      end
    end else begin : g_fp
      always_comb begin
        w_search_grant = '0;
        w_search_valid = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
          if (in_valid[k]) begin
            w_search_valid = 1'b1;
            w_search_grant = SEL_W'(k);
          end
        end
      end
    end
  endgenerate

  always_comb begin
    if (r_state == ST_LOCKED) begin
      w_grant       = r_lock_ch;
      w_grant_valid = in_valid[r_lock_ch];
    end else begin
      w_grant       = w_search_grant;
      w_grant_valid = w_search_valid;
    end
  end

  assign w_load = !r_out_valid || out_ready;
  assign w_xfer = w_load && w_grant_valid && !rst;

  always_comb begin
    in_ready   = '0;
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant == SEL_W'(i)) begin
        in_ready[i] = w_load && w_grant_valid && !rst;
        w_sel_data  = in_data[i*DATA_W +: DATA_W];
        w_sel_last  = in_last[i];
      end
    end
  end

  // Pointer only advances at packet boundaries so a long packet costs its
  // channel its turn exactly once.
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_ch;
    w_rr_nxt    = r_rr_ptr;
    if (w_xfer) begin
      if (w_sel_last) begin
        w_state_nxt = ST_IDLE;
        w_rr_nxt    = (w_grant == SEL_W'(NUM_CH - 1)) ? '0 : w_grant + SEL_W'(1);
      end else begin
        w_state_nxt = ST_LOCKED;
        w_lock_nxt  = w_grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_lock_ch <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_lock_ch <= w_lock_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_load) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_sel_data;
        r_out_last <= w_sel_last;
        r_out_ch   <= w_grant;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_ch    = r_out_ch;

endmodule

`default_nettype wire
